// File: rtl/bank_timing_tracker_pkg.sv
//------------------------------------------------------------------------------
// Module   : bank_timing_tracker_pkg
// Purpose  : Shared types and helpers for the per-bank DRAM timing tracker.
//            - cmd_t          : command bus encoding (3'd7 is reserved)
//            - recode_state_t : last-command code kept per bank
//            - sat_load       : saturating "earliest-next-command" load
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bank_timing_tracker_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_t;

  typedef enum logic [2:0] {
    CODE_IDLE                 = 3'd0,
    CODE_ACTIVE_TO_READ_WRITE = 3'd1,
    CODE_READ_TO_PRECHARGE    = 3'd2,
    CODE_WRITE_TO_PRECHARGE   = 3'd3,
    CODE_PRECHARGE_TO_ACTIVE  = 3'd4,
    CODE_PRECHARGE_TO_REFRESH = 3'd5,
    CODE_READ_TO_ACTIVE       = 3'd6,
    CODE_WRITE_TO_ACTIVE      = 3'd7
  } recode_state_t;

  // Next counter value: max(cnt-1 saturating at 0, req-1).
  // req = 0 yields a plain saturating decrement.
  function automatic int unsigned sat_load(input int unsigned cnt,
                                           input int unsigned req);
    int unsigned dec;
    int unsigned tgt;
    dec = (cnt == 0) ? 0 : cnt - 1;
    tgt = (req == 0) ? 0 : req - 1;
    return (dec > tgt) ? dec : tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bank_timing_tracker_if.sv
//------------------------------------------------------------------------------
// Module   : bank_timing_tracker_if
// Purpose  : Command / status bundle between the command FSM (master) and the
//            timing tracker (slave).
//   cmd_valid, cmd_type, cmd_bank, cmd_auto_pre, cmd_bl4   : master -> slave
//   act_ok, rdwr_ok, pre_ok, ref_ok, bank_open, recode,
//   protocol_err                                           : slave -> master
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bank_timing_tracker_if #(
  parameter int NUM_BANKS = 8
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                        cmd_valid;
  logic [2:0]                  cmd_type;
  logic [BANK_W-1:0]           cmd_bank;
  logic                        cmd_auto_pre;
  logic                        cmd_bl4;
  logic [NUM_BANKS-1:0]        act_ok;
  logic [NUM_BANKS-1:0]        rdwr_ok;
  logic [NUM_BANKS-1:0]        pre_ok;
  logic                        ref_ok;
  logic [NUM_BANKS-1:0]        bank_open;
  logic [NUM_BANKS-1:0][2:0]   recode;
  logic                        protocol_err;

  modport master (
    output cmd_valid, cmd_type, cmd_bank, cmd_auto_pre, cmd_bl4,
    input  act_ok, rdwr_ok, pre_ok, ref_ok, bank_open, recode, protocol_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_bank, cmd_auto_pre, cmd_bl4,
    output act_ok, rdwr_ok, pre_ok, ref_ok, bank_open, recode, protocol_err
  );
endinterface

`default_nettype wire

// File: rtl/bank_timing_tracker_bank_timer.sv
//------------------------------------------------------------------------------
// Module   : bank_timer
// Purpose  : Timing state of one DRAM bank: RD/WR (rcd), PRE and ACT
//            earliest-next-command counters, open flag and last-command code.
// Ports    : clk, rst            clock / synchronous active-high reset
//            i_act..i_ref        accepted-command strobes (i_prea/i_ref are
//                                rank-wide, the others already bank-selected)
//            i_auto_pre, i_bl4   RD/WR qualifiers
//            o_open              bank has an open row
//            o_*_zero            corresponding counter has expired
//            o_recode            last-command code
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bank_timer
  import bank_timing_tracker_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int T_RCD = 11,
  parameter int T_RP  = 11,
  parameter int T_RAS = 28,
  parameter int T_RC  = 39,
  parameter int T_RTP = 6,
  parameter int T_WR  = 12,
  parameter int T_WL  = 9,
  parameter int T_RFC = 44
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    i_act,
  input  wire logic    i_rd,
  input  wire logic    i_wr,
  input  wire logic    i_pre,
  input  wire logic    i_prea,
  input  wire logic    i_ref,
  input  wire logic    i_auto_pre,
  input  wire logic    i_bl4,
  output logic         o_open,
  output logic         o_rcd_zero,
  output logic         o_pre_zero,
  output logic         o_act_zero,
  output recode_state_t o_recode
);

  localparam int unsigned c_rd_ap = T_RTP + T_RP;

  logic [CNT_W-1:0] r_rcd;
  logic [CNT_W-1:0] r_pre;
  logic [CNT_W-1:0] r_act;
  logic             r_open;
  recode_state_t    r_recode;
  int unsigned      w_wr_rec;

  function automatic logic [CNT_W-1:0] f_ld(input logic [CNT_W-1:0] cnt,
                                            input int unsigned req);
    return CNT_W'(sat_load(32'(cnt), req));
  endfunction

  // Write recovery depends on the burst length of this particular write.
  assign w_wr_rec = T_WL + (i_bl4 ? 2 : 4) + T_WR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcd    <= '0;
      r_pre    <= '0;
      r_act    <= '0;
      r_open   <= 1'b0;
      r_recode <= CODE_IDLE;
    end else begin
      r_rcd <= f_ld(r_rcd, 0);
      r_pre <= f_ld(r_pre, 0);
      r_act <= f_ld(r_act, 0);
      if (i_act) begin
        r_rcd    <= f_ld(r_rcd, T_RCD);
        r_pre    <= f_ld(r_pre, T_RAS);
        r_act    <= f_ld(r_act, T_RC);
        r_open   <= 1'b1;
        r_recode <= CODE_ACTIVE_TO_READ_WRITE;
      end
      if (i_rd) begin
        r_pre    <= f_ld(r_pre, T_RTP);
        r_recode <= CODE_READ_TO_PRECHARGE;
        if (i_auto_pre) begin
          r_act    <= f_ld(r_act, c_rd_ap);
          r_open   <= 1'b0;
          r_recode <= CODE_READ_TO_ACTIVE;
        end
      end
      if (i_wr) begin
        r_pre    <= f_ld(r_pre, w_wr_rec);
        r_recode <= CODE_WRITE_TO_PRECHARGE;
        if (i_auto_pre) begin
          r_act    <= f_ld(r_act, w_wr_rec + T_RP);
          r_open   <= 1'b0;
          r_recode <= CODE_WRITE_TO_ACTIVE;
        end
      end
      // PREA only precharges banks that actually hold an open row.
      if (i_pre || (i_prea && r_open)) begin
        r_act    <= f_ld(r_act, T_RP);
        r_open   <= 1'b0;
        r_recode <= CODE_PRECHARGE_TO_ACTIVE;
      end
      if (i_prea) begin
        r_recode <= CODE_PRECHARGE_TO_REFRESH;
      end
      if (i_ref) begin
        r_act <= f_ld(r_act, T_RFC);
      end
    end
  end

  assign o_open     = r_open;
  assign o_rcd_zero = (r_rcd == '0);
  assign o_pre_zero = (r_pre == '0);
  assign o_act_zero = (r_act == '0);
  assign o_recode   = r_recode;

endmodule

`default_nettype wire

// File: rtl/bank_timing_tracker.sv
//------------------------------------------------------------------------------
// Module   : bank_timing_tracker
// Purpose  : Per-bank DRAM timing tracker with rank-level tRRD / tFAW gating,
//            PREA / REF handling and a protocol-error pulse.
// Ports    : clk, rst   clock / synchronous active-high reset
//            bus        bank_timing_tracker_if.slave (command in, ok flags,
//                       bank_open, recode, protocol_err out)
// Options  : BANK_TIMING_TFAW_EN - when defined, a 4-entry ring of activate
//            ages enforces tFAW; otherwise faw_ok is tied high.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 6,
  parameter int T_RCD     = 11,
  parameter int T_RP      = 11,
  parameter int T_RAS     = 28,
  parameter int T_RC      = 39,
  parameter int T_RTP     = 6,
  parameter int T_WR      = 12,
  parameter int T_WL      = 9,
  parameter int T_RRD     = 5,
  parameter int T_FAW     = 24,
  parameter int T_RFC     = 44
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bank_timing_tracker_if.slave  bus
);

  logic [NUM_BANKS-1:0] w_sel;
  logic [NUM_BANKS-1:0] w_open;
  logic [NUM_BANKS-1:0] w_rcd_zero;
  logic [NUM_BANKS-1:0] w_pre_zero;
  logic [NUM_BANKS-1:0] w_act_zero;
  logic [NUM_BANKS-1:0] w_act_ok;
  logic [NUM_BANKS-1:0] w_rdwr_ok;
  logic [NUM_BANKS-1:0] w_pre_ok;
  logic                 w_ref_ok;
  logic                 w_faw_ok;
  logic                 w_legal;
  logic                 w_acc;
  logic                 w_do_act, w_do_rd, w_do_wr, w_do_pre, w_do_prea, w_do_ref;
  logic [CNT_W-1:0]     r_rrd;
  logic                 r_err;

  function automatic logic [CNT_W-1:0] f_ld(input logic [CNT_W-1:0] cnt,
                                            input int unsigned req);
    return CNT_W'(sat_load(32'(cnt), req));
  endfunction

  assign w_sel = NUM_BANKS'(1) << bus.cmd_bank;

  // Flags are purely a function of registered state.
  assign w_rdwr_ok = w_open & w_rcd_zero;
  assign w_pre_ok  = w_open & w_pre_zero;
  assign w_act_ok  = ~w_open & w_act_zero & {NUM_BANKS{(r_rrd == '0) & w_faw_ok}};
  assign w_ref_ok  = ~(|w_open) & (&w_act_zero);

  always_comb begin
    w_legal = 1'b0;
    case (bus.cmd_type)
      CMD_NOP, CMD_PREA: w_legal = 1'b1;
      CMD_ACT:           w_legal = |(w_act_ok & w_sel);
      CMD_RD, CMD_WR:    w_legal = |(w_rdwr_ok & w_sel);
      CMD_PRE:           w_legal = |(w_pre_ok & w_sel);
      CMD_REF:           w_legal = w_ref_ok;
      default:           w_legal = 1'b0;
    endcase
  end

  // An illegal command is dropped entirely; only its error pulse survives.
  assign w_acc     = bus.cmd_valid & w_legal;
  assign w_do_act  = w_acc & (bus.cmd_type == CMD_ACT);
  assign w_do_rd   = w_acc & (bus.cmd_type == CMD_RD);
  assign w_do_wr   = w_acc & (bus.cmd_type == CMD_WR);
  assign w_do_pre  = w_acc & (bus.cmd_type == CMD_PRE);
  assign w_do_prea = w_acc & (bus.cmd_type == CMD_PREA);
  assign w_do_ref  = w_acc & (bus.cmd_type == CMD_REF);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    recode_state_t w_code;
    bank_timer #(
      .CNT_W (CNT_W), .T_RCD (T_RCD), .T_RP (T_RP), .T_RAS (T_RAS),
      .T_RC  (T_RC),  .T_RTP (T_RTP), .T_WR (T_WR), .T_WL  (T_WL),
      .T_RFC (T_RFC)
    ) u_bank_timer (
      .clk        (clk),
      .rst        (rst),
      .i_act      (w_do_act & w_sel[b]),
      .i_rd       (w_do_rd  & w_sel[b]),
      .i_wr       (w_do_wr  & w_sel[b]),
      .i_pre      (w_do_pre & w_sel[b]),
      .i_prea     (w_do_prea),
      .i_ref      (w_do_ref),
      .i_auto_pre (bus.cmd_auto_pre),
      .i_bl4      (bus.cmd_bl4),
      .o_open     (w_open[b]),
      .o_rcd_zero (w_rcd_zero[b]),
      .o_pre_zero (w_pre_zero[b]),
      .o_act_zero (w_act_zero[b]),
      .o_recode   (w_code)
    );
    assign bus.recode[b] = w_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrd <= '0;
      r_err <= 1'b0;
    end else begin
      r_rrd <= w_do_act ? f_ld(r_rrd, T_RRD) : f_ld(r_rrd, 0);
      r_err <= bus.cmd_valid & ~w_legal;
    end
  end

`ifdef BANK_TIMING_TFAW_EN
  // Ring of activate ages, written in issue order, so the slot under the
  // pointer always holds the oldest of the last four ACTs. A fifth ACT is
  // legal once that oldest age has run out.
  logic [3:0][CNT_W-1:0] r_faw_age;
  logic [1:0]            r_faw_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_faw_age <= '0;
      r_faw_ptr <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_faw_age[i] <= f_ld(r_faw_age[i], 0);
      end
      if (w_do_act) begin
        r_faw_age[r_faw_ptr] <= f_ld(r_faw_age[r_faw_ptr], T_FAW);
        r_faw_ptr            <= r_faw_ptr + 2'd1;
      end
    end
  end

  assign w_faw_ok = (r_faw_age[r_faw_ptr] == '0);
`else
  assign w_faw_ok = 1'b1;
`endif

  assign bus.act_ok       = w_act_ok;
  assign bus.rdwr_ok      = w_rdwr_ok;
  assign bus.pre_ok       = w_pre_ok;
  assign bus.ref_ok       = w_ref_ok;
  assign bus.bank_open    = w_open;
  assign bus.protocol_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bank_timing_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_bank_timing_tracker
// Purpose  : Scoreboard bench for bank_timing_tracker. A reference model keeps
//            absolute "earliest legal cycle" times per bank and a list of
//            recent ACT times; expected flags are queued per cycle and a
//            monitor on the falling edge compares them with the DUT.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bank_timing_tracker;
  import bank_timing_tracker_pkg::*;

  localparam int NB = 8, CW = 6;
  localparam int T_RCD = 11, T_RP = 11, T_RAS = 28, T_RC = 39, T_RTP = 6;
  localparam int T_WR = 12, T_WL = 9, T_RRD = 5, T_FAW = 24, T_RFC = 44;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_timing_tracker_if #(.NUM_BANKS(NB)) bus();

  bank_timing_tracker #(
    .NUM_BANKS(NB), .CNT_W(CW), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_RC(T_RC), .T_RTP(T_RTP), .T_WR(T_WR), .T_WL(T_WL), .T_RRD(T_RRD),
    .T_FAW(T_FAW), .T_RFC(T_RFC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NB-1:0]      act_ok, rdwr_ok, pre_ok, bank_open;
    logic               ref_ok, err;
    logic [NB-1:0][2:0] recode;
    int                 cyc;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- reference model (absolute cycle times) ----------------
  int         cyc = 0;
  int         e_rdwr[NB], e_pre[NB], e_act[NB];
  int         e_rrd;
  bit         m_open[NB];
  logic [2:0] m_code[NB];
  int         act_hist[$];
  bit         m_err;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void m_reset();
    for (int b = 0; b < NB; b++) begin
      e_rdwr[b] = 0; e_pre[b] = 0; e_act[b] = 0;
      m_open[b] = 1'b0; m_code[b] = CODE_IDLE;
    end
    e_rrd = 0;
    act_hist.delete();
    m_err = 1'b0;
  endfunction

  function automatic exp_t m_flags();
    exp_t f;
    int   n;
    bit   faw_ok;
    n = 0;
    foreach (act_hist[i]) if (cyc - act_hist[i] < T_FAW) n++;
`ifdef BANK_TIMING_TFAW_EN
    faw_ok = (n < 4);
`else
    faw_ok = 1'b1;
`endif
    f.ref_ok = 1'b1;
    for (int b = 0; b < NB; b++) begin
      f.bank_open[b] = m_open[b];
      f.rdwr_ok[b]   = m_open[b] && cyc >= e_rdwr[b];
      f.pre_ok[b]    = m_open[b] && cyc >= e_pre[b];
      f.act_ok[b]    = !m_open[b] && cyc >= e_act[b] && cyc >= e_rrd && faw_ok;
      f.recode[b]    = m_code[b];
      if (m_open[b] || cyc < e_act[b]) f.ref_ok = 1'b0;
    end
    f.err = m_err;
    f.cyc = cyc;
    return f;
  endfunction

  function automatic bit m_legal(input int t, input int b);
    exp_t f;
    f = m_flags();
    case (t)
      0, 5:    return 1'b1;
      1:       return f.act_ok[b];
      2, 3:    return f.rdwr_ok[b];
      4:       return f.pre_ok[b];
      6:       return f.ref_ok;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void m_apply(input int t, input int b, input bit ap, input bit bl4);
    int rec;
    rec = T_WL + (bl4 ? 2 : 4) + T_WR;
    case (t)
      1: begin
        e_rdwr[b] = mx(e_rdwr[b], cyc + T_RCD);
        e_pre[b]  = mx(e_pre[b],  cyc + T_RAS);
        e_act[b]  = mx(e_act[b],  cyc + T_RC);
        m_open[b] = 1'b1; m_code[b] = CODE_ACTIVE_TO_READ_WRITE;
        e_rrd = mx(e_rrd, cyc + T_RRD);
        act_hist.push_back(cyc);
      end
      2: begin
        e_pre[b] = mx(e_pre[b], cyc + T_RTP); m_code[b] = CODE_READ_TO_PRECHARGE;
        if (ap) begin
          e_act[b] = mx(e_act[b], cyc + T_RTP + T_RP);
          m_open[b] = 1'b0; m_code[b] = CODE_READ_TO_ACTIVE;
        end
      end
      3: begin
        e_pre[b] = mx(e_pre[b], cyc + rec); m_code[b] = CODE_WRITE_TO_PRECHARGE;
        if (ap) begin
          e_act[b] = mx(e_act[b], cyc + rec + T_RP);
          m_open[b] = 1'b0; m_code[b] = CODE_WRITE_TO_ACTIVE;
        end
      end
      4: begin
        e_act[b] = mx(e_act[b], cyc + T_RP);
        m_open[b] = 1'b0; m_code[b] = CODE_PRECHARGE_TO_ACTIVE;
      end
      5: for (int k = 0; k < NB; k++) begin
        if (m_open[k]) begin
          e_act[k] = mx(e_act[k], cyc + T_RP);
          m_open[k] = 1'b0;
        end
        m_code[k] = CODE_PRECHARGE_TO_REFRESH;
      end
      6: for (int k = 0; k < NB; k++) e_act[k] = mx(e_act[k], cyc + T_RFC);
      default: ;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Advance one cycle and queue the flags the DUT must show in it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (act_hist.size() > 0 && cyc - act_hist[0] >= T_FAW) void'(act_hist.pop_front());
    sb_q.push_back(m_flags());
  endtask

  task automatic drive(input bit v, input int t, input int b, input bit ap,
                       input bit bl4, input bit r);
    rst              = r;
    bus.cmd_valid    = v;
    bus.cmd_type     = 3'(t);
    bus.cmd_bank     = 3'(b);
    bus.cmd_auto_pre = ap;
    bus.cmd_bl4      = bl4;
    if (r) m_reset();
    else begin
      m_err = v && !m_legal(t, b);
      if (v && !m_err) m_apply(t, b, ap, bl4);
    end
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) until the model says the command is legal, then issue it.
  task automatic issue_when_legal(input int t, input int b, input bit ap, input bit bl4);
    int n;
    n = 0;
    tick();
    while (!m_legal(t, b) && n < 200) begin
      idle();
      tick();
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_legal: cmd %0d bank %0d never legal (got timeout, want legal)", t, b);
    end
    drive(1'b1, t, b, ap, bl4, 1'b0);
  endtask

  function automatic int pick_type();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return 1;
    if (r < 50) return 2;
    if (r < 70) return 3;
    if (r < 85) return 4;
    if (r < 90) return 5;
    if (r < 98) return 6;
    return 7;
  endfunction

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int c, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("act_ok",       e.cyc, 64'(bus.act_ok),       64'(e.act_ok));
      chk("rdwr_ok",      e.cyc, 64'(bus.rdwr_ok),      64'(e.rdwr_ok));
      chk("pre_ok",       e.cyc, 64'(bus.pre_ok),       64'(e.pre_ok));
      chk("ref_ok",       e.cyc, 64'(bus.ref_ok),       64'(e.ref_ok));
      chk("bank_open",    e.cyc, 64'(bus.bank_open),    64'(e.bank_open));
      chk("recode",       e.cyc, 64'(bus.recode),       64'(e.recode));
      chk("protocol_err", e.cyc, 64'(bus.protocol_err), 64'(e.err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int  t, b;
    bit  ap, bl4, v, found;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 3'd0; bus.cmd_bank = 3'd0;
    bus.cmd_auto_pre = 1'b0; bus.cmd_bl4 = 1'b0;
    m_reset();
    tick(); drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1);   // reset wins over a command
    tick(); idle();

    // Four ACTs at the earliest tRRD slots, then a fifth held off by tFAW.
    for (int k = 0; k < 5; k++) issue_when_legal(1, k, 1'b0, 1'b0);
    // WR BL8 / BL4 and RD with auto-precharge on open banks.
    issue_when_legal(3, 0, 1'b0, 1'b0);
    issue_when_legal(3, 1, 1'b0, 1'b1);
    issue_when_legal(2, 2, 1'b1, 1'b0);
    // PREA then REF, then let tRFC run out.
    tick(); drive(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
    issue_when_legal(6, 0, 1'b0, 1'b0);
    for (int k = 0; k < 46; k++) begin tick(); idle(); end
    // Illegal RD to a closed bank, reserved opcode, then reset mid-count.
    tick(); drive(1'b1, 2, 3, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b0);
    issue_when_legal(1, 5, 1'b0, 1'b0);
    tick(); drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick(); idle();

    // Randomized traffic, mostly legal commands, occasional illegal ones
    // and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      v = 1'b1; t = 0; b = 0; found = 1'b0;
      ap = ($urandom_range(0, 3) == 0);
      bl4 = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 399) == 0) begin
        drive($urandom_range(0, 1) == 1, 1, $urandom_range(0, NB-1), ap, bl4, 1'b1);
        continue;
      end
      if ($urandom_range(0, 99) < 20) begin
        v = $urandom_range(0, 1) == 1;
        t = 0;
      end else begin
        for (int k = 0; k < 8 && !found; k++) begin
          t = pick_type();
          b = $urandom_range(0, NB-1);
          found = m_legal(t, b);
        end
        if (!found && $urandom_range(0, 3) != 0) v = 1'b0;
      end
      drive(v, t, b, ap, bl4, 1'b0);
    end

    tick(); idle();
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
